// File: rtl/bpu_types_pkg.sv
// bpu_types_pkg: shared types between the base predictor and its update generator
package bpu_types_pkg;
    localparam int BPU_PC_WIDTH  = 32;
    localparam int BPU_CTR_WIDTH = 2;
    typedef struct packed {
        logic [BPU_PC_WIDTH-1:0]  pc;
        logic [BPU_CTR_WIDTH-1:0] ctr_bits;
    } bpu_meta_t;
    typedef struct packed {
        logic                     taken;
        logic [BPU_PC_WIDTH-1:0]  pc;
        logic [BPU_CTR_WIDTH-1:0] ctr_bits;
    } bpu_update_info_t;
    typedef enum logic [1:0] {OCC_EMPTY, OCC_PARTIAL, OCC_FULL} occ_t;
endpackage

// File: rtl/bpu_meta_fifo.sv
// bpu_meta_fifo: in-order circular queue of prediction metadata
module bpu_meta_fifo
    import bpu_types_pkg::*;
#(
    parameter int W  = BPU_PC_WIDTH + BPU_CTR_WIDTH,
    parameter int AW = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    input  logic         flush,
    output logic [W-1:0] head,
    output logic         full,
    output logic         empty
);
    localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};
    logic [W-1:0]  mem [2**AW];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    occ_t          occ;
    // occupancy class derived from count
    always_comb
        occ = (count == '0) ? OCC_EMPTY : (count == DEPTH) ? OCC_FULL : OCC_PARTIAL;
    assign full  = occ == OCC_FULL;
    assign empty = occ == OCC_EMPTY;
    assign head  = mem[rd_ptr];
    // pointers and occupancy; flush discards everything queued
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + AW'(push);
            rd_ptr <= rd_ptr + AW'(pop);
            count  <= count + (AW+1)'(push) - (AW+1)'(pop);
        end
    // entry storage is deliberately left unreset
    always_ff @(posedge clk)
        if (push && !flush) mem[wr_ptr] <= push_data;
endmodule

// File: rtl/base_update_gen.sv
// base_update_gen: pairs committed branch outcomes with fetch metadata to drive predictor updates
module base_update_gen
    import bpu_types_pkg::*;
#(
    parameter int PC_WIDTH         = BPU_PC_WIDTH,
    parameter int CTR_WIDTH        = BPU_CTR_WIDTH,
    parameter int QUEUE_DEPTH_EXP2 = 3
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          pred_valid_i,
    input  logic [PC_WIDTH-1:0]           pred_pc_i,
    input  logic [CTR_WIDTH-1:0]          pred_ctr_i,
    output logic                          pred_ready_o,
    input  logic                          resolve_valid_i,
    input  logic                          resolve_taken_i,
    input  logic [PC_WIDTH-1:0]           resolve_pc_i,
    input  logic                          flush_i,
    output logic                          update_valid_o,
    output logic [PC_WIDTH+CTR_WIDTH:0]   update_info_o,
    output logic                          pc_mismatch_o,
    output logic                          resolve_drop_o
);
    localparam int MW = PC_WIDTH + CTR_WIDTH;
    logic [MW-1:0] head;
    logic          full, empty, enq, res, pop, match;
    assign pred_ready_o = !full;
    assign enq   = pred_valid_i && !full && !flush_i;
    assign res   = resolve_valid_i && !flush_i;
    assign pop   = res && !empty;
    assign match = head[MW-1 -: PC_WIDTH] == resolve_pc_i;
    bpu_meta_fifo #(.W(MW), .AW(QUEUE_DEPTH_EXP2)) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (enq),
        .push_data ({pred_pc_i, pred_ctr_i}),
        .pop       (pop),
        .flush     (flush_i),
        .head      (head),
        .full      (full),
        .empty     (empty)
    );
    // one-cycle update beat and status pulses; info holds between beats
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            update_valid_o <= 1'b0;
            update_info_o  <= '0;
            pc_mismatch_o  <= 1'b0;
            resolve_drop_o <= 1'b0;
        end else begin
            update_valid_o <= pop && match;
            pc_mismatch_o  <= pop && !match;
            resolve_drop_o <= res && empty;
            if (pop && match) update_info_o <= {resolve_taken_i, head};
        end
endmodule

// File: tb/tb_base_update_gen.sv
// tb_base_update_gen: directed self-checking bench for base_update_gen
module tb_base_update_gen;
    import bpu_types_pkg::*;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        pred_valid_i = 1'b0;
    logic [31:0] pred_pc_i = '0;
    logic [1:0]  pred_ctr_i = '0;
    logic        pred_ready_o;
    logic        resolve_valid_i = 1'b0;
    logic        resolve_taken_i = 1'b0;
    logic [31:0] resolve_pc_i = '0;
    logic        flush_i = 1'b0;
    logic        update_valid_o;
    logic [34:0] update_info_o;
    logic        pc_mismatch_o;
    logic        resolve_drop_o;
    int n_err = 0;
    int n_chk = 0;
    logic [33:0] q[$];
    logic [33:0] e;
    bpu_update_info_t exp_info;
    base_update_gen dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .pred_valid_i    (pred_valid_i),
        .pred_pc_i       (pred_pc_i),
        .pred_ctr_i      (pred_ctr_i),
        .pred_ready_o    (pred_ready_o),
        .resolve_valid_i (resolve_valid_i),
        .resolve_taken_i (resolve_taken_i),
        .resolve_pc_i    (resolve_pc_i),
        .flush_i         (flush_i),
        .update_valid_o  (update_valid_o),
        .update_info_o   (update_info_o),
        .pc_mismatch_o   (pc_mismatch_o),
        .resolve_drop_o  (resolve_drop_o)
    );
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic idle();
        pred_valid_i = 1'b0;
        resolve_valid_i = 1'b0;
        flush_i = 1'b0;
    endtask
    task automatic push(input logic [31:0] pc, input logic [1:0] ctr);
        pred_valid_i = 1'b1;
        pred_pc_i = pc;
        pred_ctr_i = ctr;
        step();
        pred_valid_i = 1'b0;
    endtask
    task automatic resolve(input logic [31:0] pc, input logic taken);
        resolve_valid_i = 1'b1;
        resolve_pc_i = pc;
        resolve_taken_i = taken;
        step();
        resolve_valid_i = 1'b0;
    endtask
    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("rst_uv", update_valid_o, 0);
        check("rst_info", update_info_o, 0);
        check("rst_mm", pc_mismatch_o, 0);
        check("rst_drop", resolve_drop_o, 0);
        rst_n = 1'b1;
        step();
        check("rst_ready", pred_ready_o, 1);
        push(32'h1C000010, 2'b01);
        check("enq_uv", update_valid_o, 0);
        resolve(32'h1C000010, 1'b1);
        exp_info = '{taken: 1'b1, pc: 32'h1C000010, ctr_bits: 2'b01};
        check("match_uv", update_valid_o, 1);
        check("match_info", update_info_o, exp_info);
        step();
        check("match_uv_pulse", update_valid_o, 0);
        check("match_info_hold", update_info_o, exp_info);
        for (int i = 0; i < 8; i++) begin
            check("fill_ready_pre", pred_ready_o, 1);
            push(32'h1000 + 32'(4 * i), 2'(i));
            q.push_back({32'h1000 + 32'(4 * i), 2'(i)});
        end
        check("full_ready", pred_ready_o, 0);
        push(32'hDEAD, 2'b11);
        check("ninth_ready", pred_ready_o, 0);
        pred_valid_i = 1'b1;
        pred_pc_i = 32'h2000;
        pred_ctr_i = 2'b11;
        resolve(q[0][33:2], 1'b0);
        e = q.pop_front();
        check("fullpop_uv", update_valid_o, 1);
        check("fullpop_info", update_info_o, {1'b0, e});
        check("fullpop_ready", pred_ready_o, 1);
        push(32'h2000, 2'b11);
        q.push_back({32'h2000, 2'b11});
        check("refill_ready", pred_ready_o, 0);
        for (int i = 0; i < 16; i++) begin
            automatic bit acc = q.size() < 8;
            pred_valid_i = 1'b1;
            pred_pc_i = 32'h3000 + 32'(4 * i);
            pred_ctr_i = 2'(i);
            resolve(q[0][33:2], 1'(i & 1));
            e = q.pop_front();
            if (acc) q.push_back({32'h3000 + 32'(4 * i), 2'(i)});
            check("pair_uv", update_valid_o, 1);
            check("pair_info", update_info_o, {1'(i & 1), e});
            check("pair_ready", pred_ready_o, 64'(q.size() < 8));
        end
        idle();
        while (q.size() > 0) begin
            resolve(q[0][33:2], 1'b1);
            e = q.pop_front();
            check("drain_info", update_info_o, {1'b1, e});
        end
        resolve(32'h1C000020, 1'b1);
        check("empty_drop", resolve_drop_o, 1);
        check("empty_uv", update_valid_o, 0);
        resolve(32'h1C000020, 1'b1);
        check("empty_drop2", resolve_drop_o, 1);
        push(32'h1C000024, 2'b10);
        check("mm_pre_drop", resolve_drop_o, 0);
        resolve(32'h1C000020, 1'b1);
        check("mm_pulse", pc_mismatch_o, 1);
        check("mm_uv", update_valid_o, 0);
        check("mm_drop", resolve_drop_o, 0);
        step();
        check("mm_pulse_end", pc_mismatch_o, 0);
        resolve(32'h1C000024, 1'b1);
        check("mm_popped", resolve_drop_o, 1);
        for (int i = 0; i < 5; i++) push(32'h4000 + 32'(4 * i), 2'(i));
        resolve(32'h4000, 1'b1);
        check("pre_flush_uv", update_valid_o, 1);
        check("pre_flush_info", update_info_o, {1'b1, 32'h4000, 2'b00});
        flush_i = 1'b1;
        pred_valid_i = 1'b1;
        pred_pc_i = 32'h4444;
        resolve(32'h4004, 1'b1);
        idle();
        check("flush_uv", update_valid_o, 0);
        check("flush_mm", pc_mismatch_o, 0);
        check("flush_drop", resolve_drop_o, 0);
        check("flush_ready", pred_ready_o, 1);
        resolve(32'h4004, 1'b1);
        check("flush_empty", resolve_drop_o, 1);
        for (int i = 0; i < 4; i++) push(32'h5000 + 32'(4 * i), 2'(i));
        resolve(32'h5000, 1'b0);
        check("ar_pending", update_valid_o, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_uv", update_valid_o, 0);
        check("ar_info", update_info_o, 0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check("ar_uv_after", update_valid_o, 0);
        check("ar_ready", pred_ready_o, 1);
        resolve(32'h5004, 1'b0);
        check("ar_lost", resolve_drop_o, 1);
        check("ar_lost_uv", update_valid_o, 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
